// File: rtl/eth_fcs_inserter.sv
// eth_fcs_inserter: appends the Ethernet FCS (CRC-32, reflected, inverted)
// to an AXI-Stream frame that arrives without one.
// Also contains `crc`, the byte-wide CRC-32 engine that the sequencer drives.
// Compile-time option FCS_PAD_EN: when defined, frames shorter than
// MIN_FRAME_BYTES are zero-padded to that length before the FCS is appended.

module crc (
  input  logic        clk,
  input  logic        sresetn,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  input  logic [7:0]  s_tdata,
  input  logic        m_tready,
  output logic [31:0] m_tdata
);

  logic [31:0] lfsr;
  logic [31:0] lfsr_nxt;

  // One byte of the reflected Ethernet CRC (polynomial 0xEDB88320).
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign lfsr_nxt = crc_byte(lfsr, s_tdata);
  // The result includes the byte currently presented, so it can be captured
  // in the same cycle as the final byte.
  assign m_tdata  = ~lfsr_nxt;

  // LFSR update on each accepted byte; reseeds after the last byte of a frame.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      lfsr <= 32'hFFFFFFFF;
    end else if (s_tvalid && m_tready) begin
      lfsr <= s_tlast ? 32'hFFFFFFFF : lfsr_nxt;
    end
  end

endmodule

module eth_fcs_inserter #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       areset,
  output logic       s_axis_tready,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic [7:0] s_axis_tdata,
  input  logic       m_axis_tready,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       busy
);

  if (MIN_FRAME_BYTES < 1 || MIN_FRAME_BYTES > 65535 ||
      (64'(1) << CNT_WIDTH) <= 64'(MIN_FRAME_BYTES)) begin : g_cfg_check
    $error("eth_fcs_inserter: MIN_FRAME_BYTES out of range or CNT_WIDTH too narrow");
  end

  typedef enum logic [2:0] {
    PASS = 3'd0,
`ifdef FCS_PAD_EN
    PAD  = 3'd1,
`endif
    FCS0 = 3'd2,
    FCS1 = 3'd3,
    FCS2 = 3'd4,
    FCS3 = 3'd5
  } state_t;

  state_t      state, state_nxt;

  logic        vld_p1;
  logic        last_p1;
  logic [7:0]  data_p1;
  logic [31:0] fcs_reg;
  logic        busy_r;

  logic        load;
  logic        s_rdy;
  logic        ld;
  logic        ld_last;
  logic [7:0]  ld_data;
  logic        crc_vld;
  logic        crc_last;
  logic [7:0]  crc_data;
  logic [31:0] crc_w;
  logic        pass_hs;
  logic        out_done;

`ifdef FCS_PAD_EN
  localparam logic [CNT_WIDTH:0] MIN_W = (CNT_WIDTH + 1)'(MIN_FRAME_BYTES);

  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 reach_min;

  // Counter increment that saturates at the minimum frame length, so long
  // frames never wrap back into the padding decision.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + 1'b1;
    return (s >= MIN_W) ? MIN_W[CNT_WIDTH-1:0] : s[CNT_WIDTH-1:0];
  endfunction

  assign reach_min = (({1'b0, cnt} + 1'b1) >= MIN_W);
`endif

  crc u_crc (
    .clk      (clk),
    .sresetn  (~areset),
    .s_tvalid (crc_vld),
    .s_tlast  (crc_last),
    .s_tdata  (crc_data),
    .m_tready (1'b1),
    .m_tdata  (crc_w)
  );

  assign load          = !vld_p1 || m_axis_tready;
  assign s_axis_tready = s_rdy && !areset;
  assign pass_hs       = (state == PASS) && s_axis_tvalid && load;
  assign out_done      = vld_p1 && last_p1 && m_axis_tready;

  assign m_axis_tvalid = vld_p1;
  assign m_axis_tlast  = last_p1;
  assign m_axis_tdata  = data_p1;
  assign busy          = busy_r;

  // Next-state, input ready, crc feed and output-stage load selection.
  always_comb begin
    state_nxt = state;
    s_rdy     = 1'b0;
    ld        = 1'b0;
    ld_last   = 1'b0;
    ld_data   = 8'h00;
    crc_vld   = 1'b0;
    crc_last  = 1'b0;
    crc_data  = 8'h00;
`ifdef FCS_PAD_EN
    cnt_nxt   = cnt;
`endif
    case (state)
      PASS: begin
        s_rdy = load;
        if (s_axis_tvalid && load) begin
          ld       = 1'b1;
          ld_data  = s_axis_tdata;
          crc_vld  = 1'b1;
          crc_data = s_axis_tdata;
`ifdef FCS_PAD_EN
          cnt_nxt  = sat_inc(cnt);
          if (s_axis_tlast) begin
            if (reach_min) begin
              crc_last  = 1'b1;
              state_nxt = FCS0;
            end else begin
              state_nxt = PAD;
            end
          end
`else
          if (s_axis_tlast) begin
            crc_last  = 1'b1;
            state_nxt = FCS0;
          end
`endif
        end
      end
`ifdef FCS_PAD_EN
      PAD: begin
        if (load) begin
          ld      = 1'b1;
          crc_vld = 1'b1;
          cnt_nxt = sat_inc(cnt);
          if (reach_min) begin
            crc_last  = 1'b1;
            state_nxt = FCS0;
          end
        end
      end
`endif
      FCS0: begin
        if (load) begin
          ld        = 1'b1;
          ld_data   = fcs_reg[7:0];
          state_nxt = FCS1;
        end
      end
      FCS1: begin
        if (load) begin
          ld        = 1'b1;
          ld_data   = fcs_reg[15:8];
          state_nxt = FCS2;
        end
      end
      FCS2: begin
        if (load) begin
          ld        = 1'b1;
          ld_data   = fcs_reg[23:16];
          state_nxt = FCS3;
        end
      end
      FCS3: begin
        if (load) begin
          ld        = 1'b1;
          ld_last   = 1'b1;
          ld_data   = fcs_reg[31:24];
          state_nxt = PASS;
`ifdef FCS_PAD_EN
          cnt_nxt   = '0;
`endif
        end
      end
      default: state_nxt = PASS;
    endcase
  end

  // State, counter, output stage and busy flag.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state   <= PASS;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= 8'h00;
      busy_r  <= 1'b0;
`ifdef FCS_PAD_EN
      cnt     <= '0;
`endif
    end else begin
      state <= state_nxt;
`ifdef FCS_PAD_EN
      cnt   <= cnt_nxt;
`endif
      // ---- output stage boundary ----
      if (load) begin
        vld_p1  <= ld;
        last_p1 <= ld_last;
        if (ld) data_p1 <= ld_data;
      end
      if (pass_hs)       busy_r <= 1'b1;
      else if (out_done) busy_r <= 1'b0;
    end
  end

  // FCS capture on the cycle the final (data or pad) byte reaches the crc.
  always_ff @(posedge clk) begin
    if (crc_last) fcs_reg <= crc_w;
  end

endmodule

// File: tb/tb_eth_fcs_inserter.sv
// Directed testbench for eth_fcs_inserter with an output scoreboard.
// Honours FCS_PAD_EN the same way the design does.

module tb_eth_fcs_inserter;

  localparam int MINB = 60;

  logic       clk = 1'b0;
  logic       areset;
  logic       s_tready, s_tvalid, s_tlast;
  logic [7:0] s_tdata;
  logic       m_tready, m_tvalid, m_tlast;
  logic [7:0] m_tdata;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] exp_q[$];
  bit         rnd_ready = 0;
  int         cyc = 0, xfers = 0, first_cyc = -1, last_cyc = -1;
  logic [7:0] last4[4];
  bit         hold_v = 0;
  logic [8:0] hold;

  always #5 clk = ~clk;

  eth_fcs_inserter #(.MIN_FRAME_BYTES(MINB), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .areset        (areset),
    .s_axis_tready (s_tready),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tdata  (s_tdata),
    .m_axis_tready (m_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tdata  (m_tdata),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC-32 (reflected, init all-ones, inverted result).
  function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ b[k][i];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic push_frame(input logic [7:0] fr[$]);
    logic [7:0]  p[$];
    logic [31:0] w;
    p = fr;
`ifdef FCS_PAD_EN
    while (p.size() < MINB) p.push_back(8'h00);
`endif
    w = ref_crc(p);
    foreach (p[i]) exp_q.push_back({1'b0, p[i]});
    exp_q.push_back({1'b0, w[7:0]});
    exp_q.push_back({1'b0, w[15:8]});
    exp_q.push_back({1'b0, w[23:16]});
    exp_q.push_back({1'b1, w[31:24]});
  endtask

  function automatic int exp_len(input int n);
`ifdef FCS_PAD_EN
    return ((n < MINB) ? MINB : n) + 4;
`else
    return n + 4;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic l, input bit gaps);
    bit done;
    int n;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    done = 0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      done = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("s_tready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input bit gaps);
    push_frame(fr);
    foreach (fr[i]) send_byte(fr[i], (i == fr.size() - 1), gaps);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  // Downstream ready: always high, or a coin flip per cycle when enabled.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare on every transfer, stall stability.
  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (areset) begin
      hold_v = 0;
    end else begin
      if (hold_v && m_tvalid)
        check("stall_hold", {23'd0, m_tlast, m_tdata}, {23'd0, hold});
      hold_v = m_tvalid && !m_tready;
      hold   = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
        check("out_byte", {23'd0, m_tlast, m_tdata}, {23'd0, e});
        xfers++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        last4[0] = last4[1];
        last4[1] = last4[2];
        last4[2] = last4[3];
        last4[3] = m_tdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] fr2[$];

    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_m_tlast",  {31'd0, m_tlast},  32'd0);
    check("rst_m_tdata",  {24'd0, m_tdata},  32'd0);
    check("rst_s_tready", {31'd0, s_tready}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    areset = 1'b0;
    @(posedge clk);
    #1;

    // "123456789": known CRC-32 0xCBF43926
    fr = {};
    for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    xfers = 0;
    send_frame(fr, 0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("t1_busy_during", {31'd0, busy}, 32'd1);
    wait_drain("t1");
    check("t1_len", xfers, exp_len(9));
`ifndef FCS_PAD_EN
    check("t1_fcs0", {24'd0, last4[0]}, 32'h26);
    check("t1_fcs1", {24'd0, last4[1]}, 32'h39);
    check("t1_fcs2", {24'd0, last4[2]}, 32'hF4);
    check("t1_fcs3", {24'd0, last4[3]}, 32'hCB);
`endif

    // single-byte frame
    fr = {8'hAB};
    xfers = 0;
    send_frame(fr, 0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    wait_drain("t2");
    check("t2_len", xfers, exp_len(1));

    // 100 random bytes with random downstream stalls and source gaps
    fr = {};
    for (int i = 0; i < 100; i++) fr.push_back(8'($urandom_range(0, 255)));
    xfers = 0;
    rnd_ready = 1;
    send_frame(fr, 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    wait_drain("t3");
    rnd_ready = 0;
    check("t3_len", xfers, exp_len(100));

    // back-to-back 60-byte frames at full rate
    fr  = {};
    fr2 = {};
    for (int i = 0; i < 60; i++) begin
      fr.push_back(8'(i * 3 + 1));
      fr2.push_back(8'(255 - i));
    end
    repeat (2) @(posedge clk);
    #1;
    xfers = 0;
    first_cyc = -1;
    send_frame(fr, 0);
    send_frame(fr2, 0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    wait_drain("t4");
    check("t4_len", xfers, 32'd128);
    check("t4_span", last_cyc - first_cyc + 1, 32'd128);

    // reset during byte 20, then a full 64-byte frame
    for (int i = 0; i < 19; i++) begin
      exp_q.push_back({1'b0, 8'(i + 8'h40)});
      send_byte(8'(i + 8'h40), 1'b0, 0);
    end
    s_tvalid = 1'b1;
    s_tdata  = 8'h53;
    s_tlast  = 1'b0;
    @(negedge clk);
    #2;
    areset = 1'b1;
    #1;
    check("t5_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("t5_rst_busy",   {31'd0, busy},     32'd0);
    s_tvalid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(posedge clk);
    #1;
    check("t5_idle_tvalid", {31'd0, m_tvalid}, 32'd0);
    fr = {};
    for (int i = 0; i < 64; i++) fr.push_back(8'(i ^ 8'h5A));
    xfers = 0;
    send_frame(fr, 0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    wait_drain("t5");
    check("t5_len", xfers, 32'd68);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
